arc_microsequencer: RTL and testbench

- Microprogram control unit for the ARC datapath.
- Holds the 41-bit microinstruction register (MIR) and computes the next control-store address from the COND/JUMP fields, the PSR flags and the IR.
- Drives the datapath `mir` bus directly.
- Sequences main-memory reads and writes with a request/acknowledge handshake, stall gating and a timeout abort.
- The control-store ROM is external and combinational.

---
 rtl/arc_microsequencer.sv | 115 +++++++++++
 tb/tb_arc_microsequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arc_microsequencer.sv
// ARC microprogram sequencer: holds the MIR, computes the next control-store address,
// and runs memory reads and writes with stall gating and a timeout abort.
module arc_microsequencer #(
    parameter int          TIMEOUT  = 16,
    parameter logic [10:0] ERR_ADDR = 11'h7F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [40:0] cs_word,
    output logic [10:0] cs_addr,
    input  logic [3:0]  psr,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    output logic [40:0] mir_dp,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        bus_err,
    output logic        dbg_wait
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t          state_q, state_d;
    logic [40:0]     mir;
    logic [10:0]     upc;
    logic [CW-1:0]   wait_cnt, wait_cnt_d;
    logic            bus_err_d;
    logic [10:0]     upc_inc, seq_addr;
    logic            illegal, stall, timeout, abort;
    logic            unused_ir;

    assign unused_ir = ^{ir[29:25], ir[18:14], ir[12:0]};

    // Handshake: mem_rd/mem_wr are levels held while the word sits in MIR; the access
    // completes on the first edge where mem_ack is high, including the request cycle itself.
    assign mem_rd  = mir[19] & ~mir[18];
    assign mem_wr  = mir[18] & ~mir[19];
    assign illegal = mir[19] & mir[18];
    assign stall   = (mem_rd | mem_wr) & ~mem_ack;
    assign timeout = stall && (wait_cnt == CW'(TIMEOUT - 1));
    assign abort   = timeout | illegal;
    assign dbg_wait = (state_q == ST_WAIT);

    always_comb begin
        upc_inc  = upc + 11'd1;
        seq_addr = upc_inc;
        case (mir[13:11])
            3'b000:  seq_addr = upc_inc;
            3'b001:  seq_addr = psr[3] ? mir[10:0] : upc_inc;
            3'b010:  seq_addr = psr[2] ? mir[10:0] : upc_inc;
            3'b011:  seq_addr = psr[1] ? mir[10:0] : upc_inc;
            3'b100:  seq_addr = psr[0] ? mir[10:0] : upc_inc;
            3'b101:  seq_addr = ir[13] ? mir[10:0] : upc_inc;
            3'b110:  seq_addr = mir[10:0];
            3'b111:  seq_addr = {1'b1, ir[31:30], ir[24:19], 2'b00};
            default: seq_addr = upc_inc;
        endcase
    end

    always_comb begin
        cs_addr = seq_addr;
        if (abort) begin
            cs_addr = ERR_ADDR;
        end else if (stall) begin
            cs_addr = upc;
        end
    end

    // While held, the word writes only r0 and leaves the flags alone, so repeating it is harmless.
    always_comb begin
        mir_dp = mir;
        if (stall | illegal) begin
            mir_dp[26:20] = 7'b0;
            mir_dp[17:14] = 4'b1000;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt;
        bus_err_d  = 1'b0;
        if (abort) begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            bus_err_d  = 1'b1;
        end else if (stall) begin
            state_d    = ST_WAIT;
            wait_cnt_d = wait_cnt + CW'(1);
        end else begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            wait_cnt <= '0;
            bus_err  <= 1'b0;
            mir      <= '0;
            upc      <= 11'h7FF;
        end else begin
            state_q  <= state_d;
            wait_cnt <= wait_cnt_d;
            bus_err  <= bus_err_d;
            if (!stall || abort) begin
                mir <= cs_word;
                upc <= cs_addr;
            end
        end
    end

endmodule

// File: tb/tb_arc_microsequencer.sv
// Bench for arc_microsequencer: branch vector table, hand-written memory corner cases,
// and a randomized run against an address-level model with a ROM held in the bench.
module tb_arc_microsequencer;

    localparam int          TIMEOUT  = 16;
    localparam logic [10:0] ERR_ADDR = 11'h7F0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [40:0] cs_word;
    logic [10:0] cs_addr;
    logic [3:0]  psr = 4'h0;
    logic [31:0] ir = 32'h0;
    logic        mem_ack = 1'b0;
    logic [40:0] mir_dp;
    logic        mem_rd, mem_wr, bus_err, dbg_wait;

    logic [40:0] rom [0:2047];
    assign cs_word = rom[cs_addr];

    arc_microsequencer #(.TIMEOUT(TIMEOUT), .ERR_ADDR(ERR_ADDR)) dut (
        .clk(clk), .rst(rst), .cs_word(cs_word), .cs_addr(cs_addr),
        .psr(psr), .ir(ir), .mem_ack(mem_ack), .mir_dp(mir_dp),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .bus_err(bus_err), .dbg_wait(dbg_wait)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [54:0] exp_q[$];

    typedef struct {
        string       name;
        logic [2:0]  cond;
        logic [10:0] jump;
        logic [3:0]  psr;
        logic [31:0] ir;
        logic [10:0] exp_addr;
    } br_vec_t;

    br_vec_t vecs[11];

    // model state: address and content of the word the sequencer currently holds
    int          m_upc;
    logic [40:0] m_word;
    int          m_waits;
    bit          m_berr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic clear_rom();
        for (int a = 0; a < 2048; a++) rom[a] = '0;
    endtask

    function automatic logic [40:0] mk(input logic [5:0] c, input logic rd, input logic wr,
                                       input logic [3:0] alu, input logic [2:0] cond,
                                       input logic [10:0] jump);
        logic [40:0] w;
        w = '0;
        w[40:35] = 6'h11;
        w[34]    = 1'b1;
        w[33:28] = 6'h09;
        w[27]    = 1'b1;
        w[26:21] = c;
        w[20]    = 1'b1;
        w[19]    = rd;
        w[18]    = wr;
        w[17:14] = alu;
        w[13:11] = cond;
        w[10:0]  = jump;
        return w;
    endfunction

    function automatic logic [40:0] gated(input logic [40:0] w);
        return {w[40:27], 6'b000000, 1'b0, w[19:18], 4'b1000, w[13:0]};
    endfunction

    function automatic logic [10:0] model_next(input logic [40:0] w, input int upc,
                                               input logic [3:0] f, input logic [31:0] i);
        int seq;
        bit take;
        seq = (upc + 1) % 2048;
        take = 1'b0;
        case (int'(w[13:11]))
            1: take = f[3];
            2: take = f[2];
            3: take = f[1];
            4: take = f[0];
            5: take = i[13];
            6: take = 1'b1;
            7: return 11'(1024 + int'(i[31:30]) * 256 + int'(i[24:19]) * 4);
            default: take = 1'b0;
        endcase
        return take ? w[10:0] : 11'(seq);
    endfunction

    task automatic random_step(input int ack_den);
        logic [54:0] e;
        logic [10:0] exp_cs;
        logic [40:0] exp_dp;
        bit rd, wr, busy, stalled, illegal, abort;
        psr = 4'($urandom);
        ir = $urandom;
        mem_ack = ($urandom_range(0, ack_den - 1) == 0);
        sample();
        rd = m_word[19] && !m_word[18];
        wr = m_word[18] && !m_word[19];
        illegal = m_word[19] && m_word[18];
        busy = rd || wr;
        stalled = busy && !mem_ack;
        abort = illegal || (stalled && m_waits == TIMEOUT - 1);
        if (abort) exp_cs = ERR_ADDR;
        else if (stalled) exp_cs = 11'(m_upc);
        else exp_cs = model_next(m_word, m_upc, psr, ir);
        exp_dp = (stalled || illegal) ? gated(m_word) : m_word;
        exp_q.push_back({exp_cs, exp_dp, rd, wr, m_berr});
        e = exp_q.pop_front();
        chk("rnd_cs_addr", 64'(cs_addr), 64'(e[54:44]));
        chk("rnd_mir_dp", 64'(mir_dp), 64'(e[43:3]));
        chk("rnd_mem_rd", 64'(mem_rd), 64'(e[2]));
        chk("rnd_mem_wr", 64'(mem_wr), 64'(e[1]));
        chk("rnd_bus_err", 64'(bus_err), 64'(e[0]));
        if (abort) begin
            m_upc = int'(ERR_ADDR);
            m_waits = 0;
            m_berr = 1'b1;
        end else if (stalled) begin
            m_waits++;
            m_berr = 1'b0;
        end else begin
            m_upc = int'(exp_cs);
            m_waits = 0;
            m_berr = 1'b0;
        end
        m_word = rom[m_upc];
        tick();
    endtask

    initial begin
        logic [40:0] rdw, wrw, errw, illw, w;
        int r;

        vecs[0]  = '{"br_z_taken",    3'b010, 11'h123, 4'b0100, 32'h0, 11'h123};
        vecs[1]  = '{"br_z_not",      3'b010, 11'h123, 4'b0000, 32'h0, 11'h006};
        vecs[2]  = '{"br_n_taken",    3'b001, 11'h2AA, 4'b1000, 32'h0, 11'h2AA};
        vecs[3]  = '{"br_v_taken",    3'b011, 11'h055, 4'b0010, 32'h0, 11'h055};
        vecs[4]  = '{"br_c_taken",    3'b100, 11'h700, 4'b0001, 32'h0, 11'h700};
        vecs[5]  = '{"br_c_not",      3'b100, 11'h700, 4'b1110, 32'h0, 11'h006};
        vecs[6]  = '{"br_ir13_taken", 3'b101, 11'h1F0, 4'b0000, 32'h0000_2000, 11'h1F0};
        vecs[7]  = '{"br_ir13_not",   3'b101, 11'h1F0, 4'b1111, 32'hFFFF_DFFF, 11'h006};
        vecs[8]  = '{"br_always",     3'b110, 11'h3C3, 4'b0000, 32'h0, 11'h3C3};
        vecs[9]  = '{"br_decode",     3'b111, 11'h3C3, 4'b0000, 32'h8080_0000, 11'h640};
        vecs[10] = '{"br_seq",        3'b000, 11'h3C3, 4'b1111, 32'hFFFF_FFFF, 11'h006};

        // reset release with an all-zero control store
        clear_rom();
        do_reset();
        sample();
        chk("rst_cs_addr", 64'(cs_addr), 64'h000);
        chk("rst_mir_dp", 64'(mir_dp), 64'h0);
        chk("rst_mem_rd", 64'(mem_rd), 64'h0);
        chk("rst_mem_wr", 64'(mem_wr), 64'h0);
        chk("rst_bus_err", 64'(bus_err), 64'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            sample();
            chk("rst_step", 64'(cs_addr), 64'(k));
        end

        // branch table: word placed at 005
        foreach (vecs[v]) begin
            clear_rom();
            rom[5] = mk(6'd1, 1'b0, 1'b0, 4'b0011, vecs[v].cond, vecs[v].jump);
            psr = vecs[v].psr;
            ir = vecs[v].ir;
            do_reset();
            repeat (6) tick();
            sample();
            chk(vecs[v].name, 64'(cs_addr), 64'(vecs[v].exp_addr));
            chk({vecs[v].name, "_mir"}, 64'(mir_dp), 64'(rom[5]));
        end
        psr = 4'h0;
        ir = 32'h0;

        // read with three wait cycles
        clear_rom();
        rdw = mk(6'd5, 1'b1, 1'b0, 4'b0101, 3'b000, 11'h000);
        rom[0] = rdw;
        do_reset();
        tick();
        for (int k = 1; k <= 3; k++) begin
            sample();
            chk("rd_wait_mem_rd", 64'(mem_rd), 64'h1);
            chk("rd_wait_c", 64'(mir_dp[26:21]), 64'h0);
            chk("rd_wait_alu", 64'(mir_dp[17:14]), 64'h8);
            chk("rd_wait_hold", 64'(cs_addr), 64'h000);
            tick();
        end
        mem_ack = 1'b1;
        sample();
        chk("rd_ack_mem_rd", 64'(mem_rd), 64'h1);
        chk("rd_ack_mir", 64'(mir_dp), 64'(rdw));
        chk("rd_ack_next", 64'(cs_addr), 64'h001);
        tick();
        mem_ack = 1'b0;
        sample();
        chk("rd_done_mem_rd", 64'(mem_rd), 64'h0);
        chk("rd_done_next", 64'(cs_addr), 64'h002);

        // zero-wait read
        do_reset();
        mem_ack = 1'b1;
        tick();
        sample();
        chk("rd0_mem_rd", 64'(mem_rd), 64'h1);
        chk("rd0_mir", 64'(mir_dp), 64'(rdw));
        chk("rd0_next", 64'(cs_addr), 64'h001);
        tick();
        mem_ack = 1'b0;
        sample();
        chk("rd0_after", 64'(cs_addr), 64'h002);

        // write timeout
        clear_rom();
        wrw = mk(6'd7, 1'b0, 1'b1, 4'b0110, 3'b110, 11'h100);
        errw = mk(6'd2, 1'b0, 1'b0, 4'b0001, 3'b000, 11'h000);
        rom[0] = wrw;
        rom[ERR_ADDR] = errw;
        do_reset();
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            sample();
            chk("to_mem_wr", 64'(mem_wr), 64'h1);
            chk("to_bus_err_low", 64'(bus_err), 64'h0);
            chk("to_cs_addr", 64'(cs_addr), (k == TIMEOUT) ? 64'(ERR_ADDR) : 64'h000);
            tick();
        end
        sample();
        chk("to_bus_err", 64'(bus_err), 64'h1);
        chk("to_err_word", 64'(mir_dp), 64'(errw));
        chk("to_mem_wr_off", 64'(mem_wr), 64'h0);
        chk("to_next", 64'(cs_addr), 64'h7F1);
        mem_ack = 1'b1;
        tick();
        sample();
        chk("to_bus_err_pulse", 64'(bus_err), 64'h0);
        chk("to_late_ack", 64'(cs_addr), 64'h7F2);
        chk("to_late_wr", 64'(mem_wr), 64'h0);
        mem_ack = 1'b0;

        // illegal RD&WR word
        clear_rom();
        illw = mk(6'd3, 1'b1, 1'b1, 4'b0011, 3'b110, 11'h055);
        rom[0] = illw;
        rom[ERR_ADDR] = errw;
        do_reset();
        tick();
        sample();
        chk("ill_mem_rd", 64'(mem_rd), 64'h0);
        chk("ill_mem_wr", 64'(mem_wr), 64'h0);
        chk("ill_gated", 64'(mir_dp), 64'(gated(illw)));
        chk("ill_cs_addr", 64'(cs_addr), 64'(ERR_ADDR));
        tick();
        sample();
        chk("ill_bus_err", 64'(bus_err), 64'h1);
        chk("ill_err_word", 64'(mir_dp), 64'(errw));
        tick();
        sample();
        chk("ill_bus_err_end", 64'(bus_err), 64'h0);

        // reset asserted in the second cycle of a read
        clear_rom();
        rom[0] = rdw;
        do_reset();
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rstw_mir_dp", 64'(mir_dp), 64'h0);
        chk("rstw_mem_rd", 64'(mem_rd), 64'h0);
        chk("rstw_cs_addr", 64'(cs_addr), 64'h000);
        @(posedge clk);
        #1 rst = 1'b1;
        sample();
        chk("rstw_restart", 64'(cs_addr), 64'h000);
        tick();
        sample();
        chk("rstw_refetch", 64'(mir_dp), 64'(gated(rdw)));
        chk("rstw_refetch_rd", 64'(mem_rd), 64'h1);

        // randomized run against the model
        for (int a = 0; a < 2048; a++) begin
            w = {$urandom, $urandom};
            r = $urandom_range(0, 99);
            if (r < 70) w[19:18] = 2'b00;
            else if (r < 82) w[19:18] = 2'b10;
            else if (r < 94) w[19:18] = 2'b01;
            else w[19:18] = 2'b11;
            rom[a] = w;
        end
        do_reset();
        m_upc = 2047;
        m_word = '0;
        m_waits = 0;
        m_berr = 1'b0;
        for (int n = 0; n < 1500; n++) random_step(2);
        for (int n = 0; n < 1500; n++) random_step(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
